drum_audio_out: RTL and testbench

//  Consumes the centre-node amplitude produced by the drum column array once per

---
 rtl/drum_audio_out_if.sv | 28 ++
 rtl/drum_audio_out.sv | 118 +++++++++++
 tb/tb_drum_audio_out.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/drum_audio_out_if.sv
// Stream-side bundle of drum_audio_out: step-sample input, codec handshake and status.
// The master drives samples and audio_ready; the slave (the DUT) drives audio and status.
interface drum_audio_out_if #(
    parameter int NODE_W  = 18,
    parameter int OUT_W   = 32,
    parameter int FIFO_AW = 3,
    parameter int DROP_W  = 16
);
    logic                enable;
    logic                sample_valid;
    logic [NODE_W-1:0]   centre_node;
    logic                audio_ready;
    logic                audio_valid;
    logic [OUT_W-1:0]    audio_data;
    logic                audio_chan;
    logic [FIFO_AW:0]    fifo_count;
    logic [DROP_W-1:0]   drop_count;

    modport master (
        output enable, sample_valid, centre_node, audio_ready,
        input  audio_valid, audio_data, audio_chan, fifo_count, drop_count
    );

    modport slave (
        input  enable, sample_valid, centre_node, audio_ready,
        output audio_valid, audio_data, audio_chan, fifo_count, drop_count
    );
endinterface

// File: rtl/drum_audio_out.sv
// Converts the drum's centre-node amplitude to 32-bit PCM, buffers it in a small FIFO
// and emits every sample twice (left then right) over a valid/ready handshake.
module drum_audio_out #(
    parameter int NODE_W  = 18,
    parameter int OUT_W   = 32,
    parameter int SHIFT   = 14,
    parameter int FIFO_AW = 3,
    parameter int DROP_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    drum_audio_out_if.slave   bus
);
    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int WIDE_W = OUT_W + SHIFT;

    typedef enum logic [1:0] {IDLE, LEFT, RIGHT} state_t;

    state_t               state_q;
    logic [OUT_W-1:0]     mem [DEPTH];
    logic [FIFO_AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [FIFO_AW:0]     count_q;
    logic [DROP_W-1:0]    drop_q;
    logic [OUT_W-1:0]     data_q;
    logic                 chan_q;
    logic                 valid_q;

    logic [WIDE_W-1:0]    wide_d;
    logic [OUT_W-1:0]     conv_d;
    logic                 fifo_empty, fifo_full, pop_d, push_req_d, push_d, drop_d;

    // Everything above the output sign bit must replicate it, otherwise clamp.
    always_comb begin
        wide_d = {{(WIDE_W-NODE_W){bus.centre_node[NODE_W-1]}}, bus.centre_node} << SHIFT;
        if (wide_d[WIDE_W-1:OUT_W-1] == '0 || wide_d[WIDE_W-1:OUT_W-1] == '1)
            conv_d = wide_d[OUT_W-1:0];
        else if (wide_d[WIDE_W-1])
            conv_d = {1'b1, {(OUT_W-1){1'b0}}};
        else
            conv_d = {1'b0, {(OUT_W-1){1'b1}}};
    end

    always_comb begin
        fifo_empty = (count_q == '0);
        fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
        pop_d      = !fifo_empty &&
                     (state_q == IDLE || (state_q == RIGHT && bus.audio_ready));
        push_req_d = bus.sample_valid && bus.enable;
        // A full FIFO still accepts a word when the head leaves on the same edge.
        push_d     = push_req_d && (!fifo_full || pop_d);
        drop_d     = push_req_d && !push_d;
    end

    always_ff @(posedge clk) begin
        if (push_d)
            mem[wr_ptr_q] <= conv_d;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            drop_q   <= '0;
            data_q   <= '0;
            chan_q   <= 1'b0;
            valid_q  <= 1'b0;
        end else begin
            if (push_d)
                wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_d)
                rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push_d && !pop_d)
                count_q <= count_q + 1'b1;
            else if (pop_d && !push_d)
                count_q <= count_q - 1'b1;
            if (drop_d && drop_q != '1)
                drop_q <= drop_q + 1'b1;

            case (state_q)
                IDLE: begin
                    if (pop_d) begin
                        data_q  <= mem[rd_ptr_q];
                        chan_q  <= 1'b0;
                        valid_q <= 1'b1;
                        state_q <= LEFT;
                    end
                end
                LEFT: begin
                    if (bus.audio_ready) begin
                        chan_q  <= 1'b1;
                        state_q <= RIGHT;
                    end
                end
                RIGHT: begin
                    if (bus.audio_ready) begin
                        if (pop_d) begin
                            data_q  <= mem[rd_ptr_q];
                            chan_q  <= 1'b0;
                            state_q <= LEFT;
                        end else begin
                            valid_q <= 1'b0;
                            state_q <= IDLE;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.audio_valid = valid_q;
    assign bus.audio_data  = data_q;
    assign bus.audio_chan  = chan_q;
    assign bus.fifo_count  = count_q;
    assign bus.drop_count  = drop_q;
endmodule

// File: tb/tb_drum_audio_out.sv
// Bench for drum_audio_out: fixed vector table, hand-built corner sequences and a
// randomized run checked cycle by cycle against a queue-based reference model.
module tb_drum_audio_out;
    localparam int NODE_W  = 18;
    localparam int OUT_W   = 32;
    localparam int SHIFT   = 14;
    localparam int FIFO_AW = 3;
    localparam int DROP_W  = 16;
    localparam int DEPTH   = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    drum_audio_out_if #(.NODE_W(NODE_W), .OUT_W(OUT_W), .FIFO_AW(FIFO_AW), .DROP_W(DROP_W)) bus ();

    drum_audio_out #(
        .NODE_W(NODE_W), .OUT_W(OUT_W), .SHIFT(SHIFT), .FIFO_AW(FIFO_AW), .DROP_W(DROP_W)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;

    // Reference model: buffered words, the word on the output, and the drop total.
    logic [31:0] m_fifo[$];
    bit          m_valid;
    bit          m_chan;
    logic [31:0] m_data;
    int          m_drop;
    logic [32:0] got_q[$];

    typedef struct {
        bit          en;
        bit          sv;
        logic [17:0] node;
        bit          rdy;
        bit          ev;
        logic [31:0] ed;
        bit          ec;
        int          ecnt;
        int          edrop;
    } vec_t;
    vec_t tbl[17];

    function automatic logic [31:0] conv(input logic [17:0] n);
        longint v;
        v = longint'($signed(n)) * 16384;
        if (v > 64'sd2147483647)  v = 64'sd2147483647;
        if (v < -64'sd2147483648) v = -64'sd2147483648;
        return v[31:0];
    endfunction

    task automatic model_reset();
        m_fifo.delete();
        m_valid = 0;
        m_chan  = 0;
        m_data  = '0;
        m_drop  = 0;
    endtask

    task automatic model_edge(input bit en, input bit sv, input logic [17:0] node, input bit rdy);
        bit pop, push_req, accept;
        pop      = (m_fifo.size() > 0) && (!m_valid || (m_chan && rdy));
        push_req = sv && en;
        accept   = push_req && (m_fifo.size() < DEPTH || pop);
        if (!m_valid) begin
            if (pop) begin
                m_data  = m_fifo.pop_front();
                m_chan  = 0;
                m_valid = 1;
            end
        end else if (rdy) begin
            if (!m_chan) m_chan = 1;
            else if (pop) begin
                m_data = m_fifo.pop_front();
                m_chan = 0;
            end else m_valid = 0;
        end
        if (accept) m_fifo.push_back(conv(node));
        else if (push_req && m_drop < 65535) m_drop++;
    endtask

    task automatic check_val(input string name, input logic [63:0] got, input logic [63:0] exp);
        total_cnt++;
        if (got === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    task automatic check_model(input string tag);
        bit ok;
        ok = (bus.audio_valid === m_valid) &&
             (bus.fifo_count === 4'(m_fifo.size())) &&
             (bus.drop_count === 16'(m_drop)) &&
             (!m_valid || (bus.audio_data === m_data && bus.audio_chan === m_chan));
        total_cnt++;
        if (ok) pass_cnt++;
        else $display("FAIL %s: got v=%0b d=%h c=%0b cnt=%0d drop=%0d expected v=%0b d=%h c=%0b cnt=%0d drop=%0d",
                      tag, bus.audio_valid, bus.audio_data, bus.audio_chan, bus.fifo_count, bus.drop_count,
                      m_valid, m_data, m_chan, m_fifo.size(), m_drop);
    endtask

    // Drive inputs, log any transfer happening at the coming edge, advance one clock.
    task automatic step(input bit en, input bit sv, input logic [17:0] node, input bit rdy);
        bus.enable       = en;
        bus.sample_valid = sv;
        bus.centre_node  = node;
        bus.audio_ready  = rdy;
        if (bus.audio_valid && rdy) got_q.push_back({bus.audio_chan, bus.audio_data});
        @(posedge clk);
        model_edge(en, sv, node, rdy);
        #1;
    endtask

    initial begin
        logic [17:0] nodes[10];
        logic [17:0] extra, n6;
        logic [32:0] exp_q[$];
        int          guard;
        bit          ok;

        tbl[0]  = '{1, 1, 18'h01000, 1, 0, 32'h0,        0, 1, 0};
        tbl[1]  = '{1, 0, 18'h00000, 1, 1, 32'h04000000, 0, 0, 0};
        tbl[2]  = '{1, 0, 18'h00000, 1, 1, 32'h04000000, 1, 0, 0};
        tbl[3]  = '{1, 0, 18'h00000, 1, 0, 32'h0,        0, 0, 0};
        tbl[4]  = '{1, 1, 18'h3F000, 1, 0, 32'h0,        0, 1, 0};
        tbl[5]  = '{1, 0, 18'h00000, 1, 1, 32'hFC000000, 0, 0, 0};
        tbl[6]  = '{1, 0, 18'h00000, 1, 1, 32'hFC000000, 1, 0, 0};
        tbl[7]  = '{1, 0, 18'h00000, 1, 0, 32'h0,        0, 0, 0};
        tbl[8]  = '{1, 1, 18'h1FFFF, 1, 0, 32'h0,        0, 1, 0};
        tbl[9]  = '{1, 1, 18'h20000, 1, 1, 32'h7FFFC000, 0, 1, 0};
        tbl[10] = '{1, 0, 18'h00000, 1, 1, 32'h7FFFC000, 1, 1, 0};
        tbl[11] = '{1, 0, 18'h00000, 1, 1, 32'h80000000, 0, 0, 0};
        tbl[12] = '{1, 0, 18'h00000, 1, 1, 32'h80000000, 1, 0, 0};
        tbl[13] = '{1, 0, 18'h00000, 1, 0, 32'h0,        0, 0, 0};
        tbl[14] = '{0, 1, 18'h01000, 1, 0, 32'h0,        0, 0, 0};
        tbl[15] = '{0, 1, 18'h01000, 0, 0, 32'h0,        0, 0, 0};
        tbl[16] = '{0, 1, 18'h3F000, 1, 0, 32'h0,        0, 0, 0};

        reset = 1'b1;
        bus.enable = 0; bus.sample_valid = 0; bus.centre_node = '0; bus.audio_ready = 0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_val("reset valid", 64'(bus.audio_valid), 64'd0);
        check_val("reset count", 64'(bus.fifo_count), 64'd0);
        check_val("reset drop",  64'(bus.drop_count), 64'd0);
        #2 reset = 1'b0;

        // Vector table: conversion, latency, back-to-back stream, enable gating.
        foreach (tbl[i]) begin
            step(tbl[i].en, tbl[i].sv, tbl[i].node, tbl[i].rdy);
            ok = (bus.audio_valid === tbl[i].ev) &&
                 (bus.fifo_count === 4'(tbl[i].ecnt)) &&
                 (bus.drop_count === 16'(tbl[i].edrop)) &&
                 (!tbl[i].ev || (bus.audio_data === tbl[i].ed && bus.audio_chan === tbl[i].ec));
            total_cnt++;
            if (ok) pass_cnt++;
            else $display("FAIL vec%0d: got v=%0b d=%h c=%0b cnt=%0d drop=%0d expected v=%0b d=%h c=%0b cnt=%0d drop=%0d",
                          i, bus.audio_valid, bus.audio_data, bus.audio_chan, bus.fifo_count, bus.drop_count,
                          tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].ecnt, tbl[i].edrop);
        end

        // Overflow with codec stalled: one word on the output plus eight buffered.
        got_q.delete();
        foreach (nodes[i]) begin
            nodes[i] = 18'($urandom);
            step(1, 1, nodes[i], 0);
            check_model($sformatf("fill%0d", i));
        end
        check_val("full count", 64'(bus.fifo_count), 64'd8);
        check_val("full drop",  64'(bus.drop_count), 64'd1);
        check_val("held data",  64'(bus.audio_data), 64'(conv(nodes[0])));
        check_val("held chan",  64'(bus.audio_chan), 64'd0);

        step(1, 0, '0, 1);
        check_model("to right");
        extra = 18'($urandom);
        step(1, 1, extra, 1);
        check_val("push+pop count", 64'(bus.fifo_count), 64'd8);
        check_val("push+pop drop",  64'(bus.drop_count), 64'd1);

        guard = 0;
        while (got_q.size() < 20 && guard < 60) begin
            step(1, 0, '0, 1);
            check_model("drain");
            guard++;
        end
        for (int i = 0; i < 9; i++) begin
            exp_q.push_back({1'b0, conv(nodes[i])});
            exp_q.push_back({1'b1, conv(nodes[i])});
        end
        exp_q.push_back({1'b0, conv(extra)});
        exp_q.push_back({1'b1, conv(extra)});
        check_val("drain len", 64'(got_q.size()), 64'd20);
        for (int i = 0; i < 20 && i < got_q.size(); i++)
            check_val($sformatf("drain word%0d", i), 64'(got_q[i]), 64'(exp_q[i]));

        // Asynchronous reset while a word is held on a stalled output.
        step(1, 1, 18'h00123, 0);
        step(1, 1, 18'h00456, 0);
        check_val("pre-reset valid", 64'(bus.audio_valid), 64'd1);
        #2 reset = 1'b1;
        #1;
        check_val("async valid", 64'(bus.audio_valid), 64'd0);
        check_val("async data",  64'(bus.audio_data),  64'd0);
        check_val("async chan",  64'(bus.audio_chan),  64'd0);
        check_val("async count", 64'(bus.fifo_count),  64'd0);
        check_val("async drop",  64'(bus.drop_count),  64'd0);
        model_reset();
        @(posedge clk);
        #3 reset = 1'b0;
        n6 = 18'h2ABCD;
        step(1, 1, n6, 1);
        check_model("post-reset push");
        step(1, 0, '0, 1);
        check_val("post-reset data", 64'(bus.audio_data), 64'(conv(n6)));
        check_val("post-reset chan", 64'(bus.audio_chan), 64'd0);
        step(1, 0, '0, 1);
        check_model("post-reset right");

        // Randomized traffic with shifting strobe/ready densities.
        for (int blk = 0; blk < 15; blk++) begin
            int sv_pct, rdy_pct;
            sv_pct  = $urandom_range(10, 90);
            rdy_pct = $urandom_range(5, 100);
            for (int c = 0; c < 200; c++) begin
                step($urandom_range(0, 9) != 0,
                     $urandom_range(0, 99) < sv_pct,
                     18'($urandom),
                     $urandom_range(0, 99) < rdy_pct);
                check_model($sformatf("rand b%0d c%0d", blk, c));
            end
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
